// File: rtl/shift_register.sv
// Serial-in, parallel-out shift register with per-cycle direction select.
// One-cycle latency from data_i to the entry flop; no backpressure, en_i=0 simply holds.
module shift_register #(
  parameter int MSB = 8
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           en_i,
  input  logic           dir_i,
  input  logic           data_i,
  output logic [MSB-1:0] data_o
);

  logic [MSB-1:0] data_d;
  logic [MSB-1:0] data_q;

  // dir_i=0 moves toward the MSB, dir_i=1 toward the LSB; the far-end bit drops off.
  always_comb begin
    data_d = data_q;
    if (en_i) begin
      if (dir_i) begin
        data_d = {data_i, data_q[MSB-1:1]};
      end else begin
        data_d = {data_q[MSB-2:0], data_i};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: tb/tb_shift_register.sv
// Bench for shift_register: directed vector table, async-reset sequences, randomized model check.
module tb_shift_register;

  localparam int MSB = 8;

  logic           clk_i;
  logic           rstn_i;
  logic           en_i;
  logic           dir_i;
  logic           data_i;
  logic [MSB-1:0] data_o;

  int checks;
  int errors;

  typedef struct {
    logic           en;
    logic           dir;
    logic           din;
    logic [MSB-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  shift_register #(.MSB(MSB)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .en_i   (en_i),
    .dir_i  (dir_i),
    .data_i (data_i),
    .data_o (data_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [MSB-1:0] act, input logic [MSB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic dir, input logic din, input logic [MSB-1:0] exp);
    vec_t v;
    v.en  = en;
    v.dir = dir;
    v.din = din;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  // Drive inputs one step after an edge so they are stable at the next edge.
  task automatic step(input logic en, input logic dir, input logic din);
    en_i   = en;
    dir_i  = dir;
    data_i = din;
    @(posedge clk_i);
    #1;
  endtask

  // Reference: the register viewed as an unsigned number.
  function automatic int model_next(input int cur, input logic en, input logic dir, input logic din);
    int limit;
    limit = 1 << MSB;
    if (!en) return cur;
    if (dir) return (cur / 2) + (din ? (limit / 2) : 0);
    return ((cur * 2) + (din ? 1 : 0)) % limit;
  endfunction

  initial begin
    int model;
    checks = 0;
    errors = 0;
    rstn_i = 1'b0;
    en_i   = 1'b0;
    dir_i  = 1'b0;
    data_i = 1'b0;

    // Hold with en_i low while toggling the other inputs.
    add(0, 0, 1, 8'h00); add(0, 1, 0, 8'h00); add(0, 1, 1, 8'h00); add(0, 0, 0, 8'h00);
    // Left shift 1,0,1,0,...
    add(1, 0, 1, 8'h01); add(1, 0, 0, 8'h02); add(1, 0, 1, 8'h05); add(1, 0, 0, 8'h0A);
    add(1, 0, 1, 8'h15); add(1, 0, 0, 8'h2A); add(1, 0, 1, 8'h55); add(1, 0, 0, 8'hAA);
    // Flush with zeros: nothing wraps around.
    add(1, 0, 0, 8'h54); add(1, 0, 0, 8'hA8); add(1, 0, 0, 8'h50); add(1, 0, 0, 8'hA0);
    add(1, 0, 0, 8'h40); add(1, 0, 0, 8'h80); add(1, 0, 0, 8'h00); add(1, 0, 0, 8'h00);
    // Right shift 1,0,1,0,...
    add(1, 1, 1, 8'h80); add(1, 1, 0, 8'h40); add(1, 1, 1, 8'hA0); add(1, 1, 0, 8'h50);
    add(1, 1, 1, 8'hA8); add(1, 1, 0, 8'h54); add(1, 1, 1, 8'hAA); add(1, 1, 0, 8'h55);
    // Load 0000_0011 from the left, then reverse direction once.
    add(1, 0, 0, 8'hAA); add(1, 0, 0, 8'h54); add(1, 0, 0, 8'hA8); add(1, 0, 0, 8'h50);
    add(1, 0, 0, 8'hA0); add(1, 0, 0, 8'h40); add(1, 0, 1, 8'h81); add(1, 0, 1, 8'h03);
    add(1, 1, 0, 8'h01); add(0, 0, 1, 8'h01); add(0, 1, 1, 8'h01);

    // Reset state before any clock edge.
    #1;
    check("reset_initial", data_o, 8'h00);
    @(posedge clk_i);
    #1;
    check("reset_held_low", data_o, 8'h00);
    rstn_i = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].dir, vecs[i].din);
      check($sformatf("vec%0d", i), data_o, vecs[i].exp);
    end

    // Async reset with nonzero contents: clears before any edge and stays clear while low.
    step(1, 0, 1);
    check("preload", data_o, 8'h03);
    #2 rstn_i = 1'b0;
    #1;
    check("async_clear", data_o, 8'h00);
    en_i = 1'b1; dir_i = 1'b0; data_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("clear_while_low", data_o, 8'h00);
    rstn_i = 1'b1;
    step(1, 0, 1);
    check("first_after_release", data_o, 8'h01);

    // Mid-shift reset pulse between edges; shifting resumes from zero.
    step(1, 1, 1);
    step(1, 1, 1);
    check("midshift_pre", data_o, 8'hC0);
    #2 rstn_i = 1'b0;
    #1;
    check("midshift_clear", data_o, 8'h00);
    #1 rstn_i = 1'b1;
    step(1, 1, 1);
    check("midshift_resume", data_o, 8'h80);

    // Randomized shifting with occasional async resets against the numeric model.
    model = 128;
    for (int n = 0; n < 400; n++) begin
      logic en, dir, din;
      en  = ($urandom_range(0, 3) != 0);
      dir = 1'($urandom_range(0, 1));
      din = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) begin
        #2 rstn_i = 1'b0;
        #1 rstn_i = 1'b1;
        model = 0;
        check($sformatf("rand_rst%0d", n), data_o, 8'h00);
      end
      step(en, dir, din);
      model = model_next(model, en, dir, din);
      check($sformatf("rand%0d", n), data_o, MSB'(model));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
